// File: rtl/seq_det_frame_ctrl.sv
// rtl/seq_det_frame_ctrl.sv - frame serializer and hit counter for the external 101/0110 detector
// Build option: SEQ_CTRL_LSB_FIRST_EN serializes each word LSB first (default MSB first).
module seq_det_frame_ctrl #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              det_din,
  output logic              det_reset,
  input  logic              det_y,
  output logic              busy,
  output logic              hit_pulse,
  output logic [CNT_W-1:0]  hit_count,
  output logic              done,
  output logic              err
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    CLEAR = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [LEN_W-1:0]   r_to_accept;
  logic [LEN_W-1:0]   r_rem;
  logic [DATA_W-1:0]  r_shift;
  logic [DATA_W-1:0]  r_hold;
  logic               r_hold_vld;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [CNT_W-1:0]   r_hit_count;
  logic               r_hit_pulse;
  logic               r_err;

  logic               w_last_bit;
  logic               w_hs;
  logic               w_underrun;
  logic               w_cur_bit;
  logic [DATA_W-1:0]  w_shifted;

`ifdef SEQ_CTRL_LSB_FIRST_EN
  assign w_cur_bit = r_shift[0];
  assign w_shifted = {1'b0, r_shift[DATA_W-1:1]};
`else
  assign w_cur_bit = r_shift[DATA_W-1];
  assign w_shifted = {r_shift[DATA_W-2:0], 1'b0};
`endif

  assign w_last_bit = (r_bit_cnt == BIT_W'(DATA_W - 1));
  assign w_hs       = in_valid & in_ready;
  // Words still owed but nothing in hold and nothing offered for bypass.
  assign w_underrun = (r_state == SHIFT) && w_last_bit && (r_rem != '0) && !r_hold_vld && !in_valid;

  assign hit_count = r_hit_count;
  assign hit_pulse = r_hit_pulse;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    det_din   = 1'b0;
    det_reset = reset;
    busy      = (r_state != IDLE);
    done      = 1'b0;
    err       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = (frame_len == '0) ? DONE : FILL;
      end
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) w_next = CLEAR;
      end
      CLEAR: begin
        det_reset = 1'b1;
        w_next    = SHIFT;
      end
      SHIFT: begin
        det_din  = w_cur_bit;
        in_ready = (r_to_accept != '0) && (!r_hold_vld || w_last_bit);
        if (w_last_bit && ((r_rem == '0) || w_underrun)) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        err    = r_err;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_to_accept <= '0;
      r_rem       <= '0;
      r_shift     <= '0;
      r_hold      <= '0;
      r_hold_vld  <= 1'b0;
      r_bit_cnt   <= '0;
      r_hit_count <= '0;
      r_hit_pulse <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_hit_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_to_accept <= frame_len;
            r_err       <= 1'b0;
            if (frame_len == '0) r_hit_count <= '0;
          end
        end
        FILL: begin
          if (w_hs) begin
            r_shift     <= in_data;
            r_to_accept <= r_to_accept - 1'b1;
            r_rem       <= r_to_accept - 1'b1;
            r_bit_cnt   <= '0;
            r_hold_vld  <= 1'b0;
          end
        end
        CLEAR: r_hit_count <= '0;
        SHIFT: begin
          r_hit_pulse <= det_y;
          if (det_y && (r_hit_count != {CNT_W{1'b1}})) r_hit_count <= r_hit_count + 1'b1;
          if (w_hs) r_to_accept <= r_to_accept - 1'b1;
          if (w_underrun) r_err <= 1'b1;
          if (w_last_bit) begin
            r_bit_cnt <= '0;
            if (r_rem != '0) begin
              r_rem <= r_rem - 1'b1;
              // Hold refills in the same cycle it hands its word to the shifter.
              if (r_hold_vld) begin
                r_shift    <= r_hold;
                r_hold_vld <= w_hs;
                if (w_hs) r_hold <= in_data;
              end else if (w_hs) begin
                r_shift <= in_data;
              end
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_shift   <= w_shifted;
            if (w_hs) begin
              r_hold     <= in_data;
              r_hold_vld <= 1'b1;
            end
          end
        end
        DONE: r_hold_vld <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_det_frame_ctrl.sv
// tb/tb_seq_det_frame_ctrl.sv - randomized frame bench with detector model and timeline reference
module tb_seq_det_frame_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, in_valid;
  logic [3:0] frame_len;
  logic [7:0] in_data;
  logic       in_ready, det_din, det_reset, det_y, busy, hit_pulse, done, err;
  logic [7:0] hit_count;

  always #5 clk = ~clk;

  seq_det_frame_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .frame_len(frame_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .det_din(det_din), .det_reset(det_reset), .det_y(det_y),
    .busy(busy), .hit_pulse(hit_pulse), .hit_count(hit_count),
    .done(done), .err(err)
  );

  // External Mealy detector: history of bits seen since its last reset.
  logic [2:0] dh = 3'b000;
  int         dv = 0;
  always @(posedge clk) begin
    if (det_reset) begin
      dh <= 3'b000;
      dv <= 0;
    end else begin
      dh <= {dh[1:0], det_din};
      if (dv < 3) dv <= dv + 1;
    end
  end
  assign det_y = ((dv >= 2) && ({dh[1:0], det_din} == 3'b101)) ||
                 ((dv >= 3) && ({dh, det_din} == 4'b0110));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  logic       chk_en = 1'b0;
  int         cyc = 0;
  logic       exp_busy, exp_rdy, exp_rdy_chk, exp_dreset, exp_din, exp_done, exp_err, exp_pulse;
  logic [7:0] exp_cnt;
  int         done_cyc, t0_cyc, pulses;
  logic [7:0] done_cnt;
  logic       done_err;
  logic [7:0] prev_cnt;
  logic [7:0] frame_words [16];

  always @(negedge clk) begin
    cyc = cyc + 1;
    #2;
    if (done === 1'b1) begin
      done_cyc = cyc;
      done_cnt = hit_count;
      done_err = err;
    end
    if (hit_pulse === 1'b1) pulses = pulses + 1;
    if (chk_en) begin
      chk("busy", busy, exp_busy);
      if (exp_rdy_chk) chk("in_ready", in_ready, exp_rdy);
      chk("det_reset", det_reset, exp_dreset);
      chk("det_din", det_din, exp_din);
      chk("done", done, exp_done);
      if (exp_done) chk("err", err, exp_err);
      chk("hit_pulse", hit_pulse, exp_pulse);
      chk("hit_count", hit_count, exp_cnt);
    end
  end

  // Drives one frame and publishes the expected outputs for each cycle,
  // derived from the bit stream and the frame timeline (start, FILL, CLEAR, 8 bits/word, DONE).
  task automatic run_frame(input int len, input int nv, input int d, input bit lazy, input bit bstart);
    bit   bits[$];
    bit   hit[$];
    int   cum[$];
    int   n, endc, wi, acc, j;
    bit   real_w;
    logic [7:0] wd;
    n = (len == 0) ? 0 : ((nv < len) ? nv : len);
    for (int w = 0; w < n; w++) begin
      wd = frame_words[w];
      for (int b = 0; b < 8; b++) begin
`ifdef SEQ_CTRL_LSB_FIRST_EN
        bits.push_back(wd[b]);
`else
        bits.push_back(wd[7-b]);
`endif
      end
    end
    cum.push_back(0);
    for (int k = 0; k < bits.size(); k++) begin
      hit.push_back(((k >= 2) && bits[k-2] && !bits[k-1] && bits[k]) ||
                    ((k >= 3) && !bits[k-3] && bits[k-2] && bits[k-1] && !bits[k]));
      cum.push_back((cum[k] + int'(hit[k]) > 255) ? 255 : cum[k] + int'(hit[k]));
    end
    endc = (len == 0) ? 1 : d + 3 + 8 * n;
    wi = 0;
    acc = 0;
    for (int c = 0; c <= endc + 1; c++) begin
      @(negedge clk);
      start     = (c == 0) || (bstart && c >= 1 && c < endc && $urandom_range(0, 5) == 0);
      frame_len = (c == 0) ? 4'(len) : 4'($urandom_range(0, 15));
      real_w    = 1'b0;
      in_data   = 8'($urandom);
      in_valid  = 1'b0;
      if (len != 0 && c >= d + 1 && wi < n) begin
        if (!lazy || wi == 0 || c == d + 2 + 8 * wi) begin
          in_valid = 1'b1;
          in_data  = frame_words[wi];
          real_w   = 1'b1;
        end
      end else if (len != 0 && c >= d + 1 && nv >= len && !lazy) begin
        in_valid = 1'b1;
      end
      exp_busy = 1'b1; exp_rdy = 1'b0; exp_rdy_chk = 1'b1; exp_dreset = 1'b0; exp_din = 1'b0;
      exp_done = 1'b0; exp_err = 1'b0; exp_pulse = 1'b0; exp_cnt = prev_cnt;
      if (c == 0 || c == endc + 1) begin
        exp_busy = 1'b0;
        exp_cnt  = (c == 0) ? prev_cnt : 8'(cum[8*n]);
      end else if (c == endc) begin
        exp_done  = 1'b1;
        exp_err   = (len != 0) && (nv < len);
        exp_cnt   = 8'(cum[8*n]);
        exp_pulse = (n > 0) ? hit[8*n-1] : 1'b0;
      end else if (c <= d + 1) begin
        exp_rdy = 1'b1;
      end else if (c == d + 2) begin
        exp_dreset = 1'b1;
      end else begin
        j = c - d - 3;
        exp_din     = bits[j];
        exp_cnt     = 8'(cum[j]);
        exp_pulse   = (j > 0) ? hit[j-1] : 1'b0;
        exp_rdy_chk = 1'b0;
      end
      chk_en = 1'b1;
      #1;
      if (c == 0) t0_cyc = cyc;
      if (in_valid && in_ready) begin
        acc++;
        if (real_w) wi++;
      end
    end
    start    = 1'b0;
    in_valid = 1'b0;
    chk("words_accepted", acc, n);
    prev_cnt = 8'(cum[8*n]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; frame_len = 4'd0; in_data = 8'd0;
    prev_cnt = 8'd0; pulses = 0; done_cyc = -1;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_hit_pulse", hit_pulse, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_det_din", det_din, 0);
    chk("rst_det_reset", det_reset, 1);
    @(negedge clk);
    reset = 1'b0;

    frame_words[0] = 8'hA5;
    pulses = 0;
    run_frame(1, 1, 0, 1'b0, 1'b0);
    chk("t1_count", done_cnt, 2);
    chk("t1_pulses", pulses, 2);
    chk("t1_latency", done_cyc - t0_cyc, 11);
    chk("t1_err", done_err, 0);

    frame_words[0] = 8'h66;
    run_frame(1, 1, 2, 1'b0, 1'b0);
    chk("t2_count", done_cnt, 2);

    frame_words[0] = 8'h01; frame_words[1] = 8'h40;
    run_frame(2, 2, 0, 1'b0, 1'b0);
`ifdef SEQ_CTRL_LSB_FIRST_EN
    chk("t3_count", done_cnt, 0);
`else
    chk("t3_count", done_cnt, 1);
`endif

    frame_words[0] = 8'hA5;
    run_frame(2, 1, 0, 1'b0, 1'b0);
    chk("t4_err", done_err, 1);
    chk("t4_count", done_cnt, 2);
    chk("t4_latency", done_cyc - t0_cyc, 11);

    run_frame(0, 0, 0, 1'b0, 1'b0);
    chk("t5_latency", done_cyc - t0_cyc, 1);
    chk("t5_count", done_cnt, 0);
    frame_words[0] = 8'h5A; frame_words[1] = 8'h3C; frame_words[2] = 8'hC3;
    run_frame(3, 3, 1, 1'b1, 1'b1);

    chk_en = 1'b0;
    done_cyc = -1;
    @(negedge clk);
    start = 1'b1; frame_len = 4'd3; in_valid = 1'b1; in_data = 8'hA5;
    @(negedge clk);
    start = 1'b0;
    repeat (7) begin
      @(negedge clk);
      in_data = 8'($urandom);
    end
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #2;
    chk("t6_busy", busy, 0);
    chk("t6_in_ready", in_ready, 0);
    chk("t6_hit_pulse", hit_pulse, 0);
    chk("t6_hit_count", hit_count, 0);
    chk("t6_done", done, 0);
    chk("t6_det_din", det_din, 0);
    repeat (3) @(negedge clk);
    chk("t6_no_done", done_cyc, -1);
    prev_cnt = 8'd0;
    frame_words[0] = 8'hA5;
    run_frame(1, 1, 0, 1'b0, 1'b0);
    chk("t6_count", done_cnt, 2);

    for (int f = 0; f < 30; f++) begin
      int len, nv, d;
      bit lz, bs;
      len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 15));
      nv  = (len > 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, len - 1)) : len;
      d   = $urandom_range(0, 3);
      lz  = 1'($urandom_range(0, 1));
      bs  = 1'($urandom_range(0, 1));
      for (int w = 0; w < 16; w++) frame_words[w] = 8'($urandom);
      run_frame(len, nv, d, lz, bs);
    end

    chk_en = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
